text_writer: RTL and testbench

- Upstream feeder for the character-map text renderer.
- Accepts simple text commands from the console controller over a valid/ready handshake: set cursor, put char, newline, clear screen.
- Converts each command into character-RAM write strobes (address, letters, ready) on the renderer's write port.
- Tracks the cursor and performs line wrap.

---
 rtl/text_pkg.sv | 21 ++
 rtl/cursor_ctrl.sv | 71 +++++++
 rtl/text_writer.sv | 126 ++++++++++++
 tb/tb_text_writer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the text writer: op codes, screen geometry and FSM states.
package text_pkg;

    localparam int          TXT_COLS   = 100;
    localparam int          TXT_ROWS   = 75;
    localparam logic [7:0]  TXT_BLANK  = 8'h20;
    localparam int          ADDR_W     = 13;

    typedef enum logic [1:0] {
        OP_SET_CURSOR = 2'b00,
        OP_PUT_CHAR   = 2'b01,
        OP_NEWLINE    = 2'b10,
        OP_CLEAR      = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/cursor_ctrl.sv
// Cursor column/row registers with advance, newline, clamped set and home,
// plus the linear char-RAM address of the current cell.
module cursor_ctrl
    import text_pkg::*;
#(
    parameter int COLS = TXT_COLS,
    parameter int ROWS = TXT_ROWS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_home,
    input  logic              i_set,
    input  logic              i_nl,
    input  logic              i_adv,
    input  logic [6:0]        i_col,
    input  logic [6:0]        i_row,
    output logic [6:0]        o_col,
    output logic [6:0]        o_row,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
    localparam logic [6:0]        LAST_ROW = 7'(ROWS - 1);
    localparam logic [ADDR_W-1:0] W_COLS   = ADDR_W'(COLS);

    logic [6:0] r_col;
    logic [6:0] r_row;
    logic [6:0] w_col_nx;
    logic [6:0] w_row_nx;
    logic [6:0] w_row_inc;

    always_comb begin
        w_col_nx  = r_col;
        w_row_nx  = r_row;
        w_row_inc = (r_row == LAST_ROW) ? 7'd0 : r_row + 7'd1;
        if (i_home) begin
            w_col_nx = 7'd0;
            w_row_nx = 7'd0;
        end else if (i_set) begin
            w_col_nx = (i_col > LAST_COL) ? LAST_COL : i_col;
            w_row_nx = (i_row > LAST_ROW) ? LAST_ROW : i_row;
        end else if (i_nl) begin
            w_col_nx = 7'd0;
            w_row_nx = w_row_inc;
        end else if (i_adv) begin
            if (r_col == LAST_COL) begin
                w_col_nx = 7'd0;
                w_row_nx = w_row_inc;
            end else begin
                w_col_nx = r_col + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= 7'd0;
            r_row <= 7'd0;
        end else begin
            r_col <= w_col_nx;
            r_row <= w_row_nx;
        end
    end

    // Widen before multiplying so the product is never truncated to 7 bits.
    assign o_addr = {{(ADDR_W-7){1'b0}}, r_col}
                  + W_COLS * {{(ADDR_W-7){1'b0}}, r_row};
    assign o_col  = r_col;
    assign o_row  = r_row;

endmodule

// File: rtl/text_writer.sv
// Turns console text commands into char-RAM write strobes; CLEAR sweeps
// every cell with the blank code while holding off new commands.
module text_writer
    import text_pkg::*;
#(
    parameter int         COLS       = TXT_COLS,
    parameter int         ROWS       = TXT_ROWS,
    parameter logic [7:0] BLANK_CHAR = TXT_BLANK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [6:0]  cmd_col,
    input  logic [6:0]  cmd_row,
    input  logic [7:0]  cmd_char,
    output logic [12:0] address,
    output logic [8:0]  letters,
    output logic        ready,
    output logic        busy,
    output logic [6:0]  cur_col,
    output logic [6:0]  cur_row
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

    state_e            r_state;
    state_e            w_state_nx;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [8:0]        r_letters;
    logic [8:0]        w_letters_nx;
    logic              r_ready;
    logic              w_ready_nx;
    logic              w_accept;
    logic              w_home;
    logic              w_set;
    logic              w_nl;
    logic              w_adv;
    logic [ADDR_W-1:0] w_cur_addr;

    cursor_ctrl #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk    (clk),
        .rst_n  (reset),
        .i_home (w_home),
        .i_set  (w_set),
        .i_nl   (w_nl),
        .i_adv  (w_adv),
        .i_col  (cmd_col),
        .i_row  (cmd_row),
        .o_col  (cur_col),
        .o_row  (cur_row),
        .o_addr (w_cur_addr)
    );

    assign cmd_ready = (r_state == ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_state_nx   = r_state;
        w_addr_nx    = r_addr;
        w_letters_nx = r_letters;
        w_ready_nx   = 1'b0;
        w_home       = 1'b0;
        w_set        = 1'b0;
        w_nl         = 1'b0;
        w_adv        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    unique case (op_e'(cmd_op))
                        OP_SET_CURSOR: w_set = 1'b1;
                        OP_NEWLINE:    w_nl  = 1'b1;
                        OP_PUT_CHAR: begin
                            w_ready_nx   = 1'b1;
                            w_addr_nx    = w_cur_addr;
                            w_letters_nx = {1'b0, cmd_char};
                            w_adv        = 1'b1;
                        end
                        OP_CLEAR: begin
                            // First blank write goes out with the state change,
                            // so busy and the strobe train line up exactly.
                            w_state_nx   = ST_CLEAR;
                            w_ready_nx   = 1'b1;
                            w_addr_nx    = '0;
                            w_letters_nx = {1'b0, BLANK_CHAR};
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                if (r_addr == LAST_CELL) begin
                    w_state_nx = ST_IDLE;
                    w_home     = 1'b1;
                end else begin
                    w_ready_nx = 1'b1;
                    w_addr_nx  = r_addr + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_letters <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_addr    <= w_addr_nx;
            r_letters <= w_letters_nx;
            r_ready   <= w_ready_nx;
        end
    end

    assign address = r_addr;
    assign letters = r_letters;
    assign ready   = r_ready;
    assign busy    = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: cursor moves, wrap, back-to-back writes,
// full CLEAR sweep and reset abort of a CLEAR.
module tb_text_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [6:0]  cmd_col = 7'd0;
    logic [6:0]  cmd_row = 7'd0;
    logic [7:0]  cmd_char = 8'd0;
    logic [12:0] address;
    logic [8:0]  letters;
    logic        ready;
    logic        busy;
    logic [6:0]  cur_col;
    logic [6:0]  cur_row;

    int n_assert = 0;
    int n_fail   = 0;

    text_writer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_col   (cmd_col),
        .cmd_row   (cmd_row),
        .cmd_char  (cmd_char),
        .address   (address),
        .letters   (letters),
        .ready     (ready),
        .busy      (busy),
        .cur_col   (cur_col),
        .cur_row   (cur_row)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one command for a single accepting edge, then samples 1 ns later.
    task automatic send(input logic [1:0] op, input logic [6:0] col,
                        input logic [6:0] row, input logic [7:0] ch);
        cmd_op    = op;
        cmd_col   = col;
        cmd_row   = row;
        cmd_char  = ch;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_let", 32'(letters), 32'd0);
        chk("rst_rdy_busy", {30'd0, ready, busy}, 32'd0);
        chk("rst_cursor", {18'd0, cur_col, cur_row}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);

        send(2'b01, 7'd0, 7'd0, 8'h41);
        chk("putA_strobe", {21'd0, ready, address}, {21'd0, 1'b1, 13'd0});
        chk("putA_let", 32'(letters), 32'h041);
        chk("putA_cursor", {18'd0, cur_col, cur_row}, {18'd0, 7'd1, 7'd0});
        tick();
        chk("putA_one_cycle", 32'(ready), 32'd0);
        chk("hold_addr_let", {10'd0, letters, address}, {10'd0, 9'h041, 13'd0});

        send(2'b00, 7'd99, 7'd2, 8'h00);
        chk("set_99_2", {18'd0, cur_col, cur_row}, {18'd0, 7'd99, 7'd2});
        chk("set_no_write", 32'(ready), 32'd0);
        send(2'b01, 7'd0, 7'd0, 8'h5A);
        chk("putZ_addr", 32'(address), 32'd299);
        chk("putZ_let", 32'(letters), 32'h05A);
        chk("putZ_wrap_col", {18'd0, cur_col, cur_row}, {18'd0, 7'd0, 7'd3});

        send(2'b00, 7'd120, 7'd80, 8'h00);
        chk("set_clamp", {18'd0, cur_col, cur_row}, {18'd0, 7'd99, 7'd74});
        send(2'b01, 7'd0, 7'd0, 8'h71);
        chk("put_last_cell", 32'(address), 32'd7499);
        chk("wrap_origin", {18'd0, cur_col, cur_row}, 32'd0);
        send(2'b01, 7'd0, 7'd0, 8'h72);
        chk("put_after_wrap", {21'd0, ready, address}, {21'd0, 1'b1, 13'd0});
        chk("cursor_1_0", {18'd0, cur_col, cur_row}, {18'd0, 7'd1, 7'd0});

        send(2'b00, 7'd5, 7'd1, 8'h00);
        cmd_op    = 2'b01;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_char = 8'h30 + 8'(i);
            tick();
            chk($sformatf("b2b_%0d", i), {13'd0, ready, letters, address},
                {13'd0, 1'b1, 9'(8'h30 + 8'(i)), 13'(105 + i)});
        end
        cmd_valid = 1'b0;
        chk("b2b_cursor", {18'd0, cur_col, cur_row}, {18'd0, 7'd9, 7'd1});
        tick();
        chk("b2b_end", 32'(ready), 32'd0);

        send(2'b10, 7'd0, 7'd0, 8'h00);
        chk("nl_cursor", {18'd0, cur_col, cur_row}, {18'd0, 7'd0, 7'd2});

        send(2'b11, 7'd0, 7'd0, 8'h00);
        cmd_op    = 2'b00;
        cmd_col   = 7'd10;
        cmd_row   = 7'd10;
        cmd_valid = 1'b1;
        for (int k = 0; k < 7500; k++) begin
            chk("clear_cycle", {10'd0, ready, busy, cmd_ready, letters, address},
                {10'd0, 1'b1, 1'b1, 1'b0, 9'h020, 13'(k)});
            tick();
        end
        chk("clear_done", {29'd0, ready, busy, cmd_ready}, {29'd0, 3'b001});
        chk("clear_home", {18'd0, cur_col, cur_row}, 32'd0);
        tick();
        chk("held_cmd", {18'd0, cur_col, cur_row}, {18'd0, 7'd10, 7'd10});
        cmd_valid = 1'b0;

        send(2'b11, 7'd0, 7'd0, 8'h00);
        repeat (3000) tick();
        chk("abort_at_3000", 32'(address), 32'd3000);
        #2 reset = 1'b0;
        #1;
        chk("abort_rdy_busy", {30'd0, ready, busy}, 32'd0);
        chk("abort_addr_let", {10'd0, letters, address}, 32'd0);
        chk("abort_cursor", {18'd0, cur_col, cur_row}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_abort_ready", {30'd0, cmd_ready, busy}, {30'd0, 2'b10});

        send(2'b00, 7'd7, 7'd4, 8'h00);
        send(2'b10, 7'd0, 7'd0, 8'h00);
        chk("nl_7_4", {18'd0, cur_col, cur_row}, {18'd0, 7'd0, 7'd5});
        chk("nl_no_write", 32'(ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
